// File: rtl/bcp_pkg.sv
// Shared types and default sizing for the BCP engine memory-init path.
package bcp_pkg;

    localparam int CLAUSE_NUM_DEFAULT = 1024;
    localparam int ADDR_W_DEFAULT     = $clog2(CLAUSE_NUM_DEFAULT);
    localparam int NUM_BANKS_DEFAULT  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } init_state_t;

endpackage

// File: rtl/init_addr_counter.sv
// Address register plus dwell counter for the init sweep.
// last_addr flags the terminal dwell cycle of the final address; advance=0 freezes both.
module init_addr_counter #(
    parameter int ADDR_W = 10,
    parameter int DWELL  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              advance,
    input  logic              clear,
    input  logic [ADDR_W-1:0] lo,
    input  logic [ADDR_W-1:0] hi,
    output logic [ADDR_W-1:0] addr,
    output logic              last_addr
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] hi_q;
    logic              dwell_end;

    assign dwell_end = (cnt == CNT_LAST);
    assign last_addr = dwell_end && (addr == hi_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            addr <= '0;
            hi_q <= '0;
        end else if (clear) begin
            cnt  <= '0;
            addr <= '0;
        end else if (load) begin
            cnt  <= '0;
            addr <= lo;
            hi_q <= hi;
        end else if (advance) begin
            if (dwell_end) begin
                cnt <= '0;
                // Final address is held so DONE still shows hi; the FSM clears it afterwards.
                if (!last_addr) begin
                    addr <= addr + ADDR_W'(1);
                end
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/bcp_mem_init_sequencer.sv
// Sweeps a clause-address range, holding per-bank enables DWELL cycles per address.
// First mem_en one cycle after start; stall freezes the sweep and drops mem_en a cycle later.
module bcp_mem_init_sequencer
    import bcp_pkg::*;
#(
    parameter int CLAUSE_NUM = CLAUSE_NUM_DEFAULT,
    parameter int ADDR_W     = $clog2(CLAUSE_NUM),
    parameter int NUM_BANKS  = NUM_BANKS_DEFAULT,
    parameter int DWELL      = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 mode,
    input  logic [ADDR_W-1:0]    range_lo,
    input  logic [ADDR_W-1:0]    range_hi,
    input  logic [NUM_BANKS-1:0] bank_mask,
    input  logic                 stall,
    input  logic                 abort,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [NUM_BANKS-1:0] mem_en,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 aborted
);

    localparam logic [ADDR_W:0]   MAX_ADDR = (ADDR_W + 1)'(CLAUSE_NUM - 1);
    localparam logic [ADDR_W-1:0] FULL_HI  = ADDR_W'(CLAUSE_NUM - 1);

    init_state_t          state, state_d;
    logic [NUM_BANKS-1:0] mask_q, mask_d, mem_en_d;
    logic [ADDR_W-1:0]    sel_lo, sel_hi;
    logic                 range_bad;
    logic                 load, advance, clear, last_addr;
    logic                 err_d, aborted_d;

    assign sel_lo    = mode ? range_lo : '0;
    assign sel_hi    = mode ? range_hi : FULL_HI;
    // Upper-bound test is widened so it stays meaningful for non-power-of-two CLAUSE_NUM.
    assign range_bad = (sel_lo > sel_hi) || ({1'b0, sel_hi} > MAX_ADDR);

    init_addr_counter #(
        .ADDR_W (ADDR_W),
        .DWELL  (DWELL)
    ) u_addr_counter (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .advance   (advance),
        .clear     (clear),
        .lo        (sel_lo),
        .hi        (sel_hi),
        .addr      (mem_addr),
        .last_addr (last_addr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            mask_q <= '0;
        end else begin
            state  <= state_d;
            mask_q <= mask_d;
        end
    end

    always_comb begin
        state_d   = state;
        mask_d    = mask_q;
        load      = 1'b0;
        advance   = 1'b0;
        clear     = 1'b0;
        err_d     = 1'b0;
        aborted_d = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    mask_d = bank_mask;
                    if (range_bad) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else begin
                        load    = 1'b1;
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                // Abort outranks completion, so a sweep aborted on its last beat never reports done.
                if (abort) begin
                    state_d   = IDLE;
                    clear     = 1'b1;
                    aborted_d = 1'b1;
                end else if (!stall) begin
                    advance = 1'b1;
                    if (last_addr) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d   = IDLE;
                clear     = 1'b1;
                aborted_d = abort;
            end
            default: begin
                state_d = IDLE;
                clear   = 1'b1;
            end
        endcase
        mem_en_d = (state_d == ACCESS && !stall) ? mask_d : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            aborted <= 1'b0;
        end else begin
            mem_en  <= mem_en_d;
            busy    <= (state_d != IDLE);
            done    <= (state_d == DONE);
            err     <= err_d;
            aborted <= aborted_d;
        end
    end

endmodule

// File: tb/tb_bcp_mem_init_sequencer.sv
// Directed bench: two instances (DWELL=2 and DWELL=1) share stimulus, CLAUSE_NUM=8.
module tb_bcp_mem_init_sequencer;

    localparam int CN = 8;
    localparam int AW = 3;
    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic          stall = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] range_lo = '0;
    logic [AW-1:0] range_hi = '0;
    logic [NB-1:0] bank_mask = '0;

    logic [AW-1:0] a1, a2;
    logic [NB-1:0] en1, en2;
    logic          b1, b2, d1, d2, e1, e2, ab1, ab2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bcp_mem_init_sequencer #(.CLAUSE_NUM(CN), .ADDR_W(AW), .NUM_BANKS(NB), .DWELL(2)) u_d2 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .range_lo(range_lo),
        .range_hi(range_hi), .bank_mask(bank_mask), .stall(stall), .abort(abort),
        .mem_addr(a2), .mem_en(en2), .busy(b2), .done(d2), .err(e2), .aborted(ab2)
    );

    bcp_mem_init_sequencer #(.CLAUSE_NUM(CN), .ADDR_W(AW), .NUM_BANKS(NB), .DWELL(1)) u_d1 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .range_lo(range_lo),
        .range_hi(range_hi), .bank_mask(bank_mask), .stall(stall), .abort(abort),
        .mem_addr(a1), .mem_en(en1), .busy(b1), .done(d1), .err(e1), .aborted(ab1)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && (b1 || b2); i++) step();
        check_val("idle_timeout", int'(b1 | b2), 0);
    endtask

    int exp_a[1:7] = '{3, 4, 4, 4, 4, 5, 5};
    int exp_e[1:7] = '{5, 5, 0, 0, 0, 5, 0};
    int exp_s[1:7] = '{0, 1, 1, 1, 0, 0, 0};
    int seen;

    initial begin
        step();
        step();
        rst = 1'b0;
        check_val("rst_addr", int'(a2), 0);
        check_val("rst_en", int'(en2), 0);
        check_val("rst_busy", int'(b2), 0);
        check_val("rst_done", int'(d2), 0);
        check_val("rst_err", int'(e2), 0);
        check_val("rst_aborted", int'(ab2), 0);

        // Full sweep on DWELL=2 with a colliding start at cycle 5.
        start = 1'b1; mode = 1'b0; bank_mask = 4'hF;
        step();
        for (int c = 1; c <= 16; c++) begin
            check_val("full_addr", int'(a2), (c - 1) / 2);
            check_val("full_en", int'(en2), 15);
            check_val("full_busy", int'(b2), 1);
            check_val("full_done", int'(d2), 0);
            start = (c == 5);
            if (c == 5) begin
                mode = 1'b1; range_lo = 3'd0; range_hi = 3'd1; bank_mask = 4'h1;
            end
            step();
        end
        check_val("full_done17", int'(d2), 1);
        check_val("full_err17", int'(e2), 0);
        check_val("full_busy17", int'(b2), 1);
        check_val("full_en17", int'(en2), 0);
        step();
        check_val("full_busy18", int'(b2), 0);
        check_val("full_done18", int'(d2), 0);
        check_val("full_addr18", int'(a2), 0);
        wait_idle();

        // Range 3..5 on DWELL=1, stall held in cycles 2..4.
        start = 1'b1; mode = 1'b1; range_lo = 3'd3; range_hi = 3'd5; bank_mask = 4'b0101;
        step();
        start = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            check_val("rng_addr", int'(a1), exp_a[c]);
            check_val("rng_en", int'(en1), exp_e[c]);
            check_val("rng_done", int'(d1), (c == 7) ? 1 : 0);
            check_val("rng_busy", int'(b1), 1);
            stall = exp_s[c][0];
            step();
        end
        check_val("rng_err", int'(e1), 0);
        check_val("rng_idle", int'(b1), 0);
        wait_idle();

        // Invalid range lo > hi.
        start = 1'b1; mode = 1'b1; range_lo = 3'd6; range_hi = 3'd2; bank_mask = 4'hF;
        step();
        start = 1'b0;
        check_val("err_done", int'(d1), 1);
        check_val("err_err", int'(e1), 1);
        check_val("err_en", int'(en1), 0);
        check_val("err_en_d2", int'(en2), 0);
        check_val("err_err_d2", int'(e2), 1);
        step();
        check_val("err_busy2", int'(b1), 0);
        check_val("err_done2", int'(d1), 0);
        check_val("err_clr2", int'(e1), 0);
        check_val("err_en2", int'(en2), 0);

        // Start together with abort in IDLE.
        start = 1'b1; abort = 1'b1; mode = 1'b0;
        step();
        start = 1'b0; abort = 1'b0;
        check_val("sa_busy", int'(b2), 0);
        check_val("sa_en", int'(en2), 0);
        step();
        check_val("sa_busy2", int'(b2), 0);

        // Abort a full DWELL=2 sweep at address 3.
        start = 1'b1; mode = 1'b0; bank_mask = 4'hF;
        step();
        start = 1'b0;
        for (int c = 1; c < 7; c++) step();
        check_val("ab_addr7", int'(a2), 3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_val("ab_busy", int'(b2), 0);
        check_val("ab_addr", int'(a2), 0);
        check_val("ab_en", int'(en2), 0);
        check_val("ab_pulse", int'(ab2), 1);
        check_val("ab_done", int'(d2), 0);
        step();
        check_val("ab_pulse_end", int'(ab2), 0);
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            if (d2 || ab2) seen = 1;
            step();
        end
        check_val("ab_quiet", seen, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        check_val("ab_restart_addr", int'(a2), 0);
        check_val("ab_restart_en", int'(en2), 15);
        check_val("ab_restart_busy", int'(b2), 1);
        wait_idle();

        // Synchronous reset mid-sweep at address 5.
        start = 1'b1; mode = 1'b0;
        step();
        start = 1'b0;
        for (int c = 1; c < 11; c++) step();
        check_val("rs_addr11", int'(a2), 5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("rs_addr", int'(a2), 0);
        check_val("rs_en", int'(en2), 0);
        check_val("rs_busy", int'(b2), 0);
        check_val("rs_done", int'(d2), 0);
        check_val("rs_aborted", int'(ab2), 0);
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            if (d2 || ab2 || b2) seen = 1;
            step();
        end
        check_val("rs_quiet", seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcp_mem_init_sequencer.md
Name: bcp_mem_init_sequencer

Overview:
- Sweeps a contiguous clause-address range of the BCP engine data memory and drives per-bank enables and addresses so the memories can be loaded or cleared before BCP starts.
- Parametrised successor of the fixed two-cycle-per-address initial sweep, with:
  - configurable clause count, dwell time and bank count;
  - full or sub-range sweep mode and a bank mask;
  - stall, abort, busy and error reporting.
- Sits between the top-level solver control FSM and the BCP engine data memories.

Parameters:
- CLAUSE_NUM, 1024, number of clause entries per bank.
- ADDR_W, $clog2(CLAUSE_NUM), address width.
- NUM_BANKS, 4, number of data-memory banks with individual enables.
- DWELL, 2, cycles mem_en is held per address (must be ≥1; 2 gives legacy timing).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  sweep request; sampled only in IDLE
- mode  in  1  0 = full sweep 0..CLAUSE_NUM-1; 1 = range sweep range_lo..range_hi
- range_lo  in  ADDR_W  first address (mode 1)
- range_hi  in  ADDR_W  last address, inclusive (mode 1)
- bank_mask  in  NUM_BANKS  banks to enable; latched at start
- stall  in  1  memory backpressure; freezes sweep
- abort  in  1  terminate sweep
- mem_addr  out  ADDR_W  current clause address
- mem_en  out  NUM_BANKS  per-bank enable
- busy  out  1  high in any non-IDLE state
- done  out  1  one-cycle pulse on normal completion or error
- err  out  1  valid with done; range invalid
- aborted  out  1  one-cycle pulse after abort

Behaviour:
- Reset (synchronous, at a rising clk with rst=1):
  - state=IDLE;
  - mem_addr=0, mem_en=0, busy=0, done=0, err=0, aborted=0;
  - internal dwell counter=0, latched mask=0.
- Reset mid-sweep aborts silently: no done, no aborted pulse.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - If start=1 and abort=0, latch lo/hi and bank_mask:
    - mode 0 uses lo=0, hi=CLAUSE_NUM-1;
    - mode 1 uses range_lo/range_hi.
  - If lo>hi or hi>CLAUSE_NUM-1: go to DONE with err latched; no mem_en is ever asserted.
  - Otherwise: mem_addr←lo, go to ACCESS.
  - start with abort both high in IDLE: start is ignored.
  - start while not IDLE: ignored, not queued.
- ACCESS:
  - mem_en = latched mask (all-zero mask is legal: sweep runs, no enables).
  - stall=1: mem_en forced 0; dwell counter and mem_addr hold.
  - stall=0: dwell counter increments. On the count reaching DWELL-1:
    - counter clears;
    - if mem_addr==hi, go to DONE;
    - else mem_addr←mem_addr+1.
  - mem_addr never wraps (hi ≤ CLAUSE_NUM-1 guaranteed).
- DONE: done=1 (and err if latched) for exactly one cycle, mem_en=0; next state IDLE, mem_addr←0, err clears.
- abort=1 in ACCESS or DONE:
  - next state IDLE, mem_addr←0, mem_en=0;
  - aborted=1 for the following single cycle (registered);
  - done is suppressed if abort coincides with the DONE cycle.
- Latency and throughput:
  - start sampled at the end of cycle 0 → first mem_en in cycle 1.
  - With no stall, N addresses take N·DWELL ACCESS cycles; done is high in cycle N·DWELL+1.
- Outputs and register structure:
  - Every output is a registered state decode; no combinational path from an input to any output.
  - mem_en depends on stall, so the stall freeze applies in the following cycle.
  - mem_addr, the dwell counter and the mask are flops.

Decomposition:
- Shared package bcp_pkg:
  - state enum init_state_t {IDLE, ACCESS, DONE};
  - CLAUSE_NUM and ADDR_W defaults;
  - NUM_BANKS default.
- One natural sub-module: init_addr_counter.
  - Holds the dwell counter plus address register.
  - Inputs: load/advance/hold.
  - Output: last_addr flag (mem_addr==hi and dwell terminal).
- The FSM stays in bcp_mem_init_sequencer.

Test Plan:
- Full sweep: CLAUSE_NUM=8, DWELL=2, mask=4'b1111, start one cycle → mem_addr steps 0..7, two cycles each with mem_en=1111; done in cycle 17; err=0; busy cycles 1–17.
- Range with stall: mode 1, lo=3, hi=5, DWELL=1, mask=4'b0101, stall=1 for 3 cycles while on addr 4 → addresses 3,4,5; mem_en=0000 during the stall; done in cycle 7.
- Error: mode 1, lo=6, hi=2 → done=1 and err=1 in cycle 1; mem_en never asserted; back in IDLE in cycle 2.
- Abort: full sweep, abort while mem_addr=3 → next cycle IDLE, mem_addr=0; aborted pulses once; done never fires; a new start then sweeps from 0.
- Start collisions: start while busy → ignored and the sweep completes unchanged; start with abort in IDLE → remains IDLE.
- Reset mid-sweep at addr 5 → all outputs 0 the next cycle; no done or aborted pulse.
